// File: rtl/dmem_write_buffer.sv
// Store buffer between the CPU data port and a slow req/ack data memory.
// Stores queue in a circular FIFO; loads forward from the youngest pending store.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Clrn,
  input  logic                     Wmem,
  input  logic [AW-1:0]            Daddr,
  input  logic [DW-1:0]            Dwrite,
  output logic [DW-1:0]            Dread,
  output logic                     En,
  output logic [AW-1:0]            m_raddr,
  input  logic [DW-1:0]            m_rdata,
  output logic                     m_req,
  output logic [AW-1:0]            m_waddr,
  output logic [DW-1:0]            m_wdata,
  input  logic                     m_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          req_q;
  logic          full_s, push_s, pop_s;
  logic          fwd_hit_s;
  logic [DW-1:0] fwd_data_s;
  logic [PW-1:0] idx_s;

  assign full_s = (count_q == (PW+1)'(DEPTH));
  assign pop_s  = req_q & m_ack;
  // A full buffer being drained this edge can still take the new store.
  assign En     = ~(Wmem & full_s & ~pop_s);
  assign push_s = Wmem & En;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1'b1);
      2'b01:   count_d = count_q - (PW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control state; m_req is registered so a push never bypasses to memory
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      req_q    <= (count_d != '0);
    end
  end

  // Entry storage; contents need no reset
  always_ff @(posedge Clk) begin
    if (push_s) begin
      addr_q[wr_ptr_q] <= Daddr;
      data_q[wr_ptr_q] <= Dwrite;
    end
  end

  // Forwarding search from oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    idx_s      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[idx_s][AW-1:2] == Daddr[AW-1:2])) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_q[idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  assign Dread   = fwd_hit_s ? fwd_data_s : m_rdata;
  assign m_raddr = Daddr;
  assign m_req   = req_q;
  assign m_waddr = addr_q[rd_ptr_q];
  assign m_wdata = data_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed self-checking bench for dmem_write_buffer (DEPTH=4).
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Clrn, Wmem, m_ack, En, m_req, empty;
  logic [31:0] Daddr, Dwrite, Dread, m_raddr, m_rdata, m_waddr, m_wdata;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .Clk(Clk), .Clrn(Clrn), .Wmem(Wmem), .Daddr(Daddr), .Dwrite(Dwrite),
    .Dread(Dread), .En(En), .m_raddr(m_raddr), .m_rdata(m_rdata),
    .m_req(m_req), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_ack(m_ack),
    .empty(empty), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Clrn = 1'b0; Wmem = 1'b0; m_ack = 1'b0; Daddr = 32'h0; Dwrite = 32'h0; m_rdata = 32'h0;
    #12;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_mreq: got %b expected 0", m_req); end
    n_checks++; if (En !== 1'b1) begin n_fail++; $display("FAIL reset_en: got %b expected 1", En); end
    Wmem = 1'b1; #1;
    n_checks++; if (En !== 1'b1) begin n_fail++; $display("FAIL reset_en_store: got %b expected 1", En); end
    Wmem = 1'b0;
    @(negedge Clk);
    Clrn = 1'b1;
  endtask

  task automatic test_single_store();
    Wmem = 1'b1; Daddr = 32'h10; Dwrite = 32'hA5A5A5A5; #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", m_req); end
    tick();
    Wmem = 1'b0; #1;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL single_mreq: got %b expected 1", m_req); end
    n_checks++; if (m_waddr !== 32'h10) begin n_fail++; $display("FAIL single_waddr: got %h expected 00000010", m_waddr); end
    n_checks++; if (m_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL single_wdata: got %h expected a5a5a5a5", m_wdata); end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0; #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count_after: got %0d expected 0", count); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL single_mreq_after: got %b expected 0", m_req); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_a [4];
    exp_a = '{32'h4, 32'h8, 32'hC, 32'h20};
    m_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      Wmem = 1'b1; Daddr = 32'(k * 4); Dwrite = 32'hF0000000 | 32'(k * 4);
      tick();
    end
    Wmem = 1'b1; Daddr = 32'h20; Dwrite = 32'hF0000020; #1;
    n_checks++; if (En !== 1'b0) begin n_fail++; $display("FAIL fill_stall: got %b expected 0", En); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    tick(); #1;
    n_checks++; if (En !== 1'b0) begin n_fail++; $display("FAIL fill_stall_hold: got %b expected 0", En); end
    n_checks++; if (m_waddr !== 32'h0) begin n_fail++; $display("FAIL fill_head0: got %h expected 00000000", m_waddr); end
    m_ack = 1'b1; #1;
    n_checks++; if (En !== 1'b1) begin n_fail++; $display("FAIL fill_en_on_ack: got %b expected 1", En); end
    tick();
    Wmem = 1'b0; m_ack = 1'b0; #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count_pushpop: got %0d expected 4", count); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (m_waddr !== exp_a[i]) begin n_fail++; $display("FAIL fill_drain_addr%0d: got %h expected %h", i, m_waddr, exp_a[i]); end
      n_checks++; if (m_wdata !== (32'hF0000000 | exp_a[i])) begin n_fail++; $display("FAIL fill_drain_data%0d: got %h expected %h", i, m_wdata, 32'hF0000000 | exp_a[i]); end
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
    end
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b expected 1", empty); end
  endtask

  task automatic test_forwarding();
    m_ack = 1'b0;
    Wmem = 1'b1; Daddr = 32'h40; Dwrite = 32'h11111111;
    tick();
    Dwrite = 32'h22222222;
    tick();
    Wmem = 1'b0; m_rdata = 32'hDEADBEEF; Daddr = 32'h40; #1;
    n_checks++; if (Dread !== 32'h22222222) begin n_fail++; $display("FAIL fwd_40: got %h expected 22222222", Dread); end
    Daddr = 32'h43; #1;
    n_checks++; if (Dread !== 32'h22222222) begin n_fail++; $display("FAIL fwd_43: got %h expected 22222222", Dread); end
    Daddr = 32'h44; #1;
    n_checks++; if (Dread !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_44: got %h expected deadbeef", Dread); end
    n_checks++; if (m_raddr !== 32'h44) begin n_fail++; $display("FAIL fwd_raddr: got %h expected 00000044", m_raddr); end
    tick();
    Wmem = 1'b1; Dwrite = 32'h33333333; #1;
    n_checks++; if (Dread !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_no_push_fwd: got %h expected deadbeef", Dread); end
    Wmem = 1'b0; Daddr = 32'h40; m_ack = 1'b1;
    tick(); #1;
    n_checks++; if (Dread !== 32'h22222222) begin n_fail++; $display("FAIL fwd_acked_entry: got %h expected 22222222", Dread); end
    tick();
    m_ack = 1'b0; #1;
    n_checks++; if (Dread !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_after_drain: got %h expected deadbeef", Dread); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fwd_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    m_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      Wmem = 1'b1; Daddr = 32'h100 + 32'(k * 4); Dwrite = 32'(k); #1;
      n_checks++; if (En !== 1'b1) begin n_fail++; $display("FAIL b2b_en%0d: got %b expected 1", k, En); end
      n_checks++; if (count > 3'd2) begin n_fail++; $display("FAIL b2b_count%0d: got %0d expected <=2", k, count); end
      if (m_req === 1'b1) got.push_back(m_waddr);
      tick();
    end
    Wmem = 1'b0;
    for (int c = 0; c < 20 && count != 3'd0; c++) begin
      #1;
      if (m_req === 1'b1) got.push_back(m_waddr);
      tick();
    end
    m_ack = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain_timeout: got %0d expected 0", count); end
    n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL b2b_nwrites: got %0d expected 10", got.size()); end
    for (int k = 0; k < got.size() && k < 10; k++) begin
      n_checks++; if (got[k] !== 32'h100 + 32'(k * 4)) begin n_fail++; $display("FAIL b2b_order%0d: got %h expected %h", k, got[k], 32'h100 + 32'(k * 4)); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] qa [$];
    logic [31:0] qd [$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] last_store [logic [31:0]];
    logic [31:0] wa, exp_d;
    int sent = 0;
    int delay;
    bit holding = 1'b0;
    bit acc, pop;
    delay = int'($urandom_range(0, 3));
    m_ack = 1'b0;
    for (int it = 0; it < 300 && !(sent == 3 * DEPTH && qa.size() == 0); it++) begin
      n_checks++; if (count !== 3'(qa.size())) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", count, qa.size()); end
      if (!holding && sent < 3 * DEPTH) begin
        Wmem = 1'b1; Daddr = 32'h200 + 32'($urandom_range(0, 4) * 4); Dwrite = $urandom; holding = 1'b1;
      end else if (!holding) begin
        Wmem = 1'b0; Daddr = 32'h200 + 32'($urandom_range(0, 19));
      end
      m_ack = (m_req === 1'b1) && (delay == 0);
      if (m_req === 1'b1 && delay > 0) delay--;
      wa = {Daddr[31:2], 2'b00};
      m_rdata = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
      #1;
      exp_d = m_rdata;
      for (int j = 0; j < qa.size(); j++) if (qa[j][31:2] == Daddr[31:2]) exp_d = qd[j];
      n_checks++; if (Dread !== exp_d) begin n_fail++; $display("FAIL wrap_fwd: got %h expected %h", Dread, exp_d); end
      if (m_req === 1'b1 && qa.size() > 0) begin
        n_checks++; if (m_waddr !== qa[0] || m_wdata !== qd[0]) begin n_fail++; $display("FAIL wrap_head: got %h/%h expected %h/%h", m_waddr, m_wdata, qa[0], qd[0]); end
      end
      acc = (Wmem === 1'b1) && (En === 1'b1);
      pop = (m_req === 1'b1) && (m_ack === 1'b1);
      tick();
      if (pop && qa.size() > 0) begin
        mem_model[{qa[0][31:2], 2'b00}] = qd[0];
        void'(qa.pop_front()); void'(qd.pop_front());
        delay = int'($urandom_range(0, 3));
      end
      if (acc) begin
        qa.push_back(Daddr); qd.push_back(Dwrite);
        last_store[{Daddr[31:2], 2'b00}] = Dwrite;
        sent++; holding = 1'b0;
      end
    end
    Wmem = 1'b0; m_ack = 1'b0;
    n_checks++; if (sent != 3 * DEPTH || qa.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: got sent=%0d pending=%0d expected %0d/0", sent, qa.size(), 3 * DEPTH); end
    foreach (last_store[a]) begin
      n_checks++;
      if (!mem_model.exists(a) || mem_model[a] !== last_store[a]) begin
        n_fail++; $display("FAIL wrap_mem_%h: got %h expected %h", a, mem_model.exists(a) ? mem_model[a] : 32'hx, last_store[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    m_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Wmem = 1'b1; Daddr = 32'h300 + 32'(k * 4); Dwrite = 32'h30 + 32'(k);
      tick();
    end
    Wmem = 1'b0; #1;
    n_checks++; if (count !== 3'd3 || m_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %0d/%b expected 3/1", count, m_req); end
    #1 Clrn = 1'b0; #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mreq: got %b expected 0", m_req); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
    tick();
    Clrn = 1'b1;
    Wmem = 1'b1; Daddr = 32'h80; Dwrite = 32'h80808080;
    tick();
    Wmem = 1'b0; #1;
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_mreq: got %b expected 1", m_req); end
    n_checks++; if (m_waddr !== 32'h80) begin n_fail++; $display("FAIL rstmid_new_waddr: got %h expected 00000080", m_waddr); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL rstmid_new_count: got %0d expected 1", count); end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0; #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_final_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    tick();
    test_single_store();
    test_fill();
    test_forwarding();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
